raid5_stripe_parity: RTL and testbench

- Sits directly upstream of the SD data-in selector.
- Accepts paired 32-bit words from the two SRAM buffers and computes their XOR parity.
- Assigns SD-card IDs to sram1, sram2 and parity for each stripe, rotating the parity card every stripe (RAID5 left-symmetric, 3 cards).
- Its registered outputs drive the selector's sram1/sram2/parity data inputs and its sram1sd/sram2sd inputs.

---
 rtl/raid5_pkg.sv | 20 ++
 rtl/raid5_rot_map.sv | 31 +++
 rtl/raid5_stripe_parity.sv | 168 ++++++++++++++++
 tb/tb_raid5_stripe_parity.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raid5_pkg.sv
// Shared types and constants for the RAID5 3-card stripe write path.
package raid5_pkg;

  typedef logic [1:0] sd_id_t;

  localparam int NUM_SD              = 3;
  localparam int WORDS_PER_BLOCK_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Rotation index walks 0,1,2,0,... one step per completed stripe.
  function automatic logic [1:0] next_rot(input logic [1:0] r);
    return (r == 2'(NUM_SD - 1)) ? 2'd0 : r + 2'd1;
  endfunction

endpackage

// File: rtl/raid5_rot_map.sv
// Left-symmetric RAID5 card assignment for 3 cards: rotation index -> card IDs.
module raid5_rot_map
  import raid5_pkg::*;
(
  input  logic [1:0] rot_i,
  output sd_id_t     sram1sd_o,
  output sd_id_t     sram2sd_o,
  output sd_id_t     parity_sd_o
);

  // Parity card is 2-r; data cards follow it cyclically. Index 3 falls back to r=0.
  always_comb begin
    sram1sd_o   = 2'd0;
    sram2sd_o   = 2'd1;
    parity_sd_o = 2'd2;
    case (rot_i)
      2'd1: begin
        sram1sd_o   = 2'd2;
        sram2sd_o   = 2'd0;
        parity_sd_o = 2'd1;
      end
      2'd2: begin
        sram1sd_o   = 2'd1;
        sram2sd_o   = 2'd2;
        parity_sd_o = 2'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/raid5_stripe_parity.sv
// Registers SRAM word pairs with their XOR parity and per-stripe rotating SD card IDs.
module raid5_stripe_parity
  import raid5_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] num_stripes,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] sram1_in,
  input  logic [31:0] sram2_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sram1,
  output logic [31:0] sram2,
  output logic [31:0] parity,
  output logic [1:0]  sram1sd,
  output logic [1:0]  sram2sd,
  output logic        stripe_done,
  output logic        busy,
  output logic        xfer_done,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_parity_sd
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // valid never depends on ready; the payload is held stable while valid && !ready.

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  state_t           state_q, state_d;
  logic [15:0]      stripes_q, stripes_d;
  logic [15:0]      stripe_cnt_q, stripe_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       rot_q, rot_d;
  logic [31:0]      s1_q, s1_d, s2_q, s2_d, par_q, par_d;
  sd_id_t           sd1_q, sd1_d, sd2_q, sd2_d;
  logic             last_q, last_d, final_q, final_d;
  logic             ov_q, ov_d;
  logic             sdone_q, sdone_d, xdone_q, xdone_d;

  sd_id_t map_sd1, map_sd2, map_psd;
  logic   handshake, accept, last_word, last_stripe;

  raid5_rot_map u_rot_map (
    .rot_i       (rot_q),
    .sram1sd_o   (map_sd1),
    .sram2sd_o   (map_sd2),
    .parity_sd_o (map_psd)
  );

  assign handshake   = ov_q && out_ready;
  assign in_ready    = (state_q == RUN) && (!ov_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign last_word   = (word_cnt_q == LAST_WORD);
  assign last_stripe = (stripe_cnt_q == stripes_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    stripes_d    = stripes_q;
    stripe_cnt_d = stripe_cnt_q;
    word_cnt_d   = word_cnt_q;
    rot_d        = rot_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    par_d        = par_q;
    sd1_d        = sd1_q;
    sd2_d        = sd2_q;
    last_d       = last_q;
    final_d      = final_q;
    ov_d         = ov_q;
    sdone_d      = handshake && last_q;
    xdone_d      = handshake && final_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_stripes != 16'd0) begin
            stripes_d    = num_stripes;
            stripe_cnt_d = 16'd0;
            word_cnt_d   = '0;
            rot_d        = 2'd0;
            state_d      = RUN;
          end else begin
            xdone_d = 1'b1;
          end
        end
      end
      RUN:     if (accept && last_word && last_stripe) state_d = DRAIN;
      DRAIN:   if (handshake && final_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // IDs travel with each word so a stalled last word keeps its stripe's mapping.
    if (accept) begin
      s1_d    = sram1_in;
      s2_d    = sram2_in;
      par_d   = sram1_in ^ sram2_in;
      sd1_d   = map_sd1;
      sd2_d   = map_sd2;
      last_d  = last_word;
      final_d = last_word && last_stripe;
      ov_d    = 1'b1;
      if (last_word) begin
        word_cnt_d   = '0;
        rot_d        = next_rot(rot_q);
        stripe_cnt_d = stripe_cnt_q + 16'd1;
      end else begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      stripes_q    <= 16'd0;
      stripe_cnt_q <= 16'd0;
      word_cnt_q   <= '0;
      rot_q        <= 2'd0;
      s1_q         <= 32'd0;
      s2_q         <= 32'd0;
      par_q        <= 32'd0;
      sd1_q        <= 2'd0;
      sd2_q        <= 2'd1;
      last_q       <= 1'b0;
      final_q      <= 1'b0;
      ov_q         <= 1'b0;
      sdone_q      <= 1'b0;
      xdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stripes_q    <= stripes_d;
      stripe_cnt_q <= stripe_cnt_d;
      word_cnt_q   <= word_cnt_d;
      rot_q        <= rot_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      par_q        <= par_d;
      sd1_q        <= sd1_d;
      sd2_q        <= sd2_d;
      last_q       <= last_d;
      final_q      <= final_d;
      ov_q         <= ov_d;
      sdone_q      <= sdone_d;
      xdone_q      <= xdone_d;
    end
  end

  assign out_valid     = ov_q;
  assign sram1         = s1_q;
  assign sram2         = s2_q;
  assign parity        = par_q;
  assign sram1sd       = sd1_q;
  assign sram2sd       = sd2_q;
  assign stripe_done   = sdone_q;
  assign xfer_done     = xdone_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;
  assign dbg_parity_sd = map_psd;

endmodule

// File: tb/tb_raid5_stripe_parity.sv
// Directed bench for raid5_stripe_parity with a transaction-level model checked every cycle.
module tb_raid5_stripe_parity;

  localparam int WPB = 4;
  localparam int EW  = 103;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [15:0] num_stripes;
  logic        in_valid, in_ready;
  logic [31:0] sram1_in, sram2_in;
  logic        out_valid, out_ready;
  logic [31:0] sram1, sram2, parity;
  logic [1:0]  sram1sd, sram2sd;
  logic        stripe_done, busy, xfer_done;
  logic [1:0]  dbg_state, dbg_parity_sd;

  raid5_stripe_parity #(.WORDS_PER_BLOCK(WPB), .CNT_W(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .num_stripes   (num_stripes),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sram1_in      (sram1_in),
    .sram2_in      (sram2_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sram1         (sram1),
    .sram2         (sram2),
    .parity        (parity),
    .sram1sd       (sram1sd),
    .sram2sd       (sram2sd),
    .stripe_done   (stripe_done),
    .busy          (busy),
    .xfer_done     (xfer_done),
    .dbg_state     (dbg_state),
    .dbg_parity_sd (dbg_parity_sd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Entry: {first, last, final, sd1[2], sd2[2], sram1[32], sram2[32], parity[32]}
  logic [EW-1:0] exp_q[$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  int          m_total = 0, acc_idx = 0, hs_idx = 0;
  bit          m_busy = 0, exp_sdone = 0, exp_xdone = 0, hold_prev = 0;
  logic [31:0] p1, p2, pp;
  logic [1:0]  pd1, pd2;
  int          acc0_cyc = 0, last_hs_cyc = 0, xdone_seen = 0;
  logic [31:0] first_par = 32'd0;
  logic [3:0]  rot_log[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [EW-1:0] e;
    bit ns, nx, exp_ir;
    int s, p;
    if (!n_rst) begin
      exp_q.delete();
      m_busy = 0; exp_sdone = 0; exp_xdone = 0; hold_prev = 0;
      acc_idx = 0; hs_idx = 0; m_total = 0;
      return;
    end
    ns = 0; nx = 0;
    chk("stripe_done", {31'd0, stripe_done}, {31'd0, exp_sdone});
    chk("xfer_done", {31'd0, xfer_done}, {31'd0, exp_xdone});
    if (xfer_done) xdone_seen++;
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    exp_ir = m_busy && (acc_idx < m_total) && (!out_valid || out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    if (hold_prev) begin
      chk("hold sram1", sram1, p1);
      chk("hold sram2", sram2, p2);
      chk("hold parity", parity, pp);
      chk("hold ids", {28'd0, sram1sd, sram2sd}, {28'd0, pd1, pd2});
    end
    if (start && !m_busy) begin
      if (num_stripes == 16'd0) nx = 1;
      else begin
        m_busy = 1; m_total = int'(num_stripes) * WPB; acc_idx = 0; hs_idx = 0;
      end
    end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sram1", sram1, e[95:64]);
      chk("sram2", sram2, e[63:32]);
      chk("parity", parity, e[31:0]);
      chk("sram1sd", {30'd0, sram1sd}, {30'd0, e[99:98]});
      chk("sram2sd", {30'd0, sram2sd}, {30'd0, e[97:96]});
      if (e[102] && (hs_idx / WPB) < 8) rot_log[hs_idx / WPB] = {sram1sd, sram2sd};
      if (hs_idx == 0) first_par = parity;
      hs_idx++;
      ns = e[101];
      if (e[100]) begin nx = 1; m_busy = 0; last_hs_cyc = cyc; end
    end
    if (in_valid && in_ready && m_busy) begin
      s = acc_idx / WPB;
      p = 2 - (s % 3);
      e = {acc_idx % WPB == 0, acc_idx % WPB == WPB - 1, acc_idx == m_total - 1,
           2'((p + 1) % 3), 2'((p + 2) % 3), sram1_in, sram2_in, sram1_in ^ sram2_in};
      exp_q.push_back(e);
      if (acc_idx == 0) acc0_cyc = cyc;
      acc_idx++;
    end
    hold_prev = out_valid && !out_ready;
    p1 = sram1; p2 = sram2; pp = parity; pd1 = sram1sd; pd2 = sram2sd;
    exp_sdone = ns; exp_xdone = nx;
  endtask

  // One clock: check at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pair(input int idx, input bit cpair);
    logic [15:0] i16;
    i16 = idx[15:0];
    if (cpair) begin
      sram1_in = 32'hFFFF0000;
      sram2_in = 32'h0F0F0F0F;
    end else begin
      sram1_in = {16'hA5A5, i16};
      sram2_in = {i16 ^ 16'h1234, 16'h3C3C};
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_stripes = n;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int total, input int stall_at, input int abort_at,
                        input int bstart_at, input bit cpair);
    int idx = 0, left = 0, budget = 0;
    bit stalled = 0, bs_done = 0, aborted = 0;
    set_pair(0, cpair);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (budget < 500) begin
      tick();
      budget++;
      start = 1'b0;
      idx = acc_idx;
      if (abort_at >= 0 && idx >= abort_at) begin aborted = 1; break; end
      if (idx >= total) in_valid = 1'b0;
      else set_pair(idx, cpair);
      if (stall_at >= 0 && idx == stall_at && !stalled) begin stalled = 1; left = 5; end
      out_ready = (left == 0);
      if (left > 0) left--;
      if (bstart_at >= 0 && idx == bstart_at && !bs_done) begin
        start = 1'b1; num_stripes = 16'd1; bs_done = 1;
      end
      if (!m_busy && exp_q.size() == 0 && idx >= total) break;
    end
    if (budget >= 500) begin
      n_vec++; n_err++;
      $display("FAIL stream timeout: got %0d accepts, expected %0d", idx, total);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      tick();
      tick();
    end
  endtask

  task automatic check_reset_vals();
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst sram1", sram1, 32'd0);
    chk("rst sram2", sram2, 32'd0);
    chk("rst parity", parity, 32'd0);
    chk("rst ids", {28'd0, sram1sd, sram2sd}, 32'h1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst pulses", {30'd0, stripe_done, xfer_done}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int xb;
    n_rst = 1'b0; start = 1'b0; num_stripes = 16'd0;
    in_valid = 1'b0; out_ready = 1'b1; sram1_in = 32'd0; sram2_in = 32'd0;
    for (int i = 0; i < 8; i++) rot_log[i] = 4'hF;
    tick(); tick();
    check_reset_vals();
    n_rst = 1'b1;
    tick();

    // Single stripe, constant pair
    do_start(16'd1);
    stream(4, -1, -1, -1, 1'b1);
    chk("single first parity", first_par, 32'hF0F00F0F);
    chk("single ids", {28'd0, rot_log[0]}, 32'h1);
    chk("single throughput", last_hs_cyc - acc0_cyc, 32'd4);

    // Four stripes with a start pulse while busy
    do_start(16'd4);
    stream(16, -1, -1, 6, 1'b0);
    chk("rot stripe0", {28'd0, rot_log[0]}, 32'h1);
    chk("rot stripe1", {28'd0, rot_log[1]}, 32'h8);
    chk("rot stripe2", {28'd0, rot_log[2]}, 32'h6);
    chk("rot stripe3", {28'd0, rot_log[3]}, 32'h1);
    chk("busy start ignored", hs_idx, 32'd16);
    chk("rot throughput", last_hs_cyc - acc0_cyc, 32'd16);

    // Backpressure across the stripe boundary
    do_start(16'd2);
    stream(8, 4, -1, -1, 1'b0);
    chk("bp words out", hs_idx, 32'd8);
    chk("bp stripe1 ids", {28'd0, rot_log[1]}, 32'h8);

    // Zero-stripe start
    xb = xdone_seen;
    do_start(16'd0);
    tick(); tick();
    chk("zero start xfer_done count", xdone_seen - xb, 32'd1);

    // Reset in the middle of a transfer
    do_start(16'd2);
    stream(8, -1, 5, -1, 1'b0);
    xb = xdone_seen;
    n_rst = 1'b0;
    tick();
    check_reset_vals();
    n_rst = 1'b1;
    tick(); tick(); tick(); tick();
    chk("no done after reset", xdone_seen - xb, 32'd0);

    // Recovery after reset
    do_start(16'd1);
    stream(4, -1, -1, -1, 1'b0);
    chk("recovery words out", hs_idx, 32'd4);
    chk("recovery ids", {28'd0, rot_log[0]}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
